// File: rtl/rr_grant_scheduler.sv
// Four-requester round-robin scheduler with bounded hold and one dead cycle between grants.
// Outputs registered: grant one cycle after request sampled; no backpressure, owner keeps it by holding req.
module rr_grant_scheduler #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       gnt_valid,
   output logic [1:0] gnt_id,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] last_q, last_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [3:0] gnt_d;
   logic       timeout_d;
   logic [1:0] winner;
   logic [1:0] scan_idx;
   logic       found;
   logic       limit_hit;

   // Scan starts just past the previous winner so it ranks last.
   always_comb begin
      winner   = 2'd0;
      found    = 1'b0;
      scan_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = last_q + 2'd1 + 2'(k);
         if (!found && req[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE, RELEASE: begin
            if (found) begin
               state_d    = GRANT;
               owner_d    = winner;
               last_d     = winner;
               hold_cnt_d = 8'd1;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!req[owner_q]) begin
               state_d = RELEASE;
            end else if (limit_hit) begin
               state_d   = RELEASE;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            owner_d    = 2'd0;
            last_d     = 2'd3;
            hold_cnt_d = 8'd0;
         end
      endcase
      gnt_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 2'd0;
         last_q     <= 2'd3;
         hold_cnt_q <= 8'd0;
         gnt        <= 4'b0000;
         gnt_valid  <= 1'b0;
         gnt_id     <= 2'd0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         gnt        <= gnt_d;
         gnt_valid  <= (state_d == GRANT);
         gnt_id     <= owner_d;
         timeout    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: vector table through a one-cycle scoreboard, plus hand-written corner sequences.
module tb_rr_grant_scheduler;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       tmo;
   } vec_t;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt4, gnt0;
   logic       gnt_valid4, gnt_valid0;
   logic [1:0] gnt_id4, gnt_id0;
   logic       timeout4, timeout0;

   int   checks;
   int   errors;
   logic mon_en;
   vec_t tbl[$];
   vec_t sbq[$];

   rr_grant_scheduler #(.MAX_HOLD(4)) dut4 (
      .clock(clock), .reset(reset), .req(req),
      .gnt(gnt4), .gnt_valid(gnt_valid4), .gnt_id(gnt_id4), .timeout(timeout4)
   );

   rr_grant_scheduler #(.MAX_HOLD(0)) dut0 (
      .clock(clock), .reset(reset), .req(req),
      .gnt(gnt0), .gnt_valid(gnt_valid0), .gnt_id(gnt_id0), .timeout(timeout0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                               input logic [1:0] id, input logic t);
      tbl.push_back('{rst: r, req: q, gnt: g, id: id, tmo: t});
   endfunction

   // Grant shape must hold on every cycle, for both instances.
   always @(negedge clock) begin
      if (mon_en) begin
         checks++;
         if (!$onehot0(gnt4) || (gnt_valid4 !== (|gnt4))) begin
            errors++;
            $display("FAIL invariant4 gnt=%b gnt_valid=%b required onehot0 and valid==|gnt", gnt4, gnt_valid4);
         end
         checks++;
         if (!$onehot0(gnt0) || (gnt_valid0 !== (|gnt0))) begin
            errors++;
            $display("FAIL invariant0 gnt=%b gnt_valid=%b required onehot0 and valid==|gnt", gnt0, gnt_valid0);
         end
      end
   end

   initial begin
      vec_t e;
      checks = 0;
      errors = 0;
      mon_en = 1'b0;
      reset  = 1'b1;
      req    = 4'b0000;

      // Basic grant/release from reset.
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0001, 4'b0001, 2'd0, 0);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // All requesting with MAX_HOLD=4: rotation with timeouts.
      add(1, 4'b1111, 4'b0000, 2'd0, 0);
      for (int a = 0; a < 4; a++) begin
         for (int n = 0; n < 4; n++) add(0, 4'b1111, 4'b0001 << a, 2'(a), 0);
         add(0, 4'b1111, 4'b0000, 2'(a), 1);
      end
      add(0, 4'b1111, 4'b0001, 2'd0, 0);
      // 0101: agent 0 releases after two cycles, agent 2 follows after the gap.
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0101, 4'b0001, 2'd0, 0);
      add(0, 4'b0101, 4'b0001, 2'd0, 0);
      add(0, 4'b0100, 4'b0000, 2'd0, 0);
      add(0, 4'b0100, 4'b0100, 2'd2, 0);
      add(0, 4'b0000, 4'b0000, 2'd2, 0);
      add(0, 4'b0000, 4'b0000, 2'd2, 0);
      // Drop on the edge the hold limit is reached: normal release, then re-grant.
      for (int n = 0; n < 4; n++) add(0, 4'b0010, 4'b0010, 2'd1, 0);
      add(0, 4'b0000, 4'b0000, 2'd1, 0);
      add(0, 4'b0010, 4'b0010, 2'd1, 0);
      // Reset during a grant to agent 2, then scan restarts at agent 0.
      add(0, 4'b0000, 4'b0000, 2'd1, 0);
      add(0, 4'b0100, 4'b0100, 2'd2, 0);
      add(1, 4'b0100, 4'b0000, 2'd0, 0);
      add(0, 4'b1010, 4'b0010, 2'd1, 0);
      add(0, 4'b0000, 4'b0000, 2'd1, 0);
      add(0, 4'b0000, 4'b0000, 2'd1, 0);

      @(posedge clock);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst;
         req   = tbl[i].req;
         sbq.push_back(tbl[i]);
         @(posedge clock);
         #1;
         e = sbq.pop_front();
         chk($sformatf("v%0d_gnt", i),       32'(gnt4),       32'(e.gnt));
         chk($sformatf("v%0d_gnt_valid", i), 32'(gnt_valid4), 32'(|e.gnt));
         chk($sformatf("v%0d_gnt_id", i),    32'(gnt_id4),    32'(e.id));
         chk($sformatf("v%0d_timeout", i),   32'(timeout4),   32'(e.tmo));
         mon_en = 1'b1;
      end

      // Request pulse entirely between edges is never granted.
      reset = 1'b0;
      req   = 4'b0001;
      #2;
      req   = 4'b0000;
      @(posedge clock);
      #1;
      chk("pulse_gnt", 32'(gnt4), 32'd0);
      chk("pulse_valid", 32'(gnt_valid4), 32'd0);

      // MAX_HOLD=0: continuous ownership with a saturating counter.
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      req   = 4'b1000;
      for (int n = 0; n < 300; n++) begin
         @(posedge clock);
         #1;
         chk($sformatf("nolimit%0d_gnt", n), 32'(gnt0), 32'h8);
         chk($sformatf("nolimit%0d_timeout", n), 32'(timeout0), 32'd0);
      end
      chk("nolimit_hold_sat", 32'(dut0.hold_cnt_q), 32'd255);
      chk("nolimit_id", 32'(gnt_id0), 32'd3);
      req = 4'b0000;
      @(posedge clock);
      #1;
      chk("nolimit_release", 32'(gnt0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
